// File: rtl/encoder_seq_ctrl_pkg.sv
// Shared encoder definitions: transfer kind codes, sequencer states and width helpers.
package encoder_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        KindHeader = 2'd0,
        KindStatus = 2'd1,
        KindTag    = 2'd2,
        KindData   = 2'd3
    } kind_e;

    typedef enum logic {
        StIdle   = 1'b0,
        StActive = 1'b1
    } state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        int unsigned span;
        res  = 0;
        span = 1;
        while (span < value) begin
            span = span << 1;
            res  = res + 1;
        end
        return res;
    endfunction

    // Word-index width; never narrower than one bit so single-word blocks still index.
    function automatic int unsigned cnt_width(input int unsigned nw);
        return (clog2(nw) < 1) ? 1 : clog2(nw);
    endfunction

endpackage

// File: rtl/encoder_seq_ctrl_word_cnt.sv
// Word index counter for the active transfer: clear, increment and terminal compare.
module encoder_seq_ctrl_word_cnt #(
    parameter int unsigned CW = 3
) (
    input  logic          clk,
    input  logic          syn_rst,
    input  logic          clear,
    input  logic          incr,
    input  logic [CW-1:0] max_idx,
    output logic [CW-1:0] cnt,
    output logic          at_max
);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (syn_rst || clear) begin
            cnt_q <= '0;
        end else if (incr) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign cnt    = cnt_q;
    assign at_max = (cnt_q == max_idx);

endmodule

// File: rtl/encoder_seq_ctrl.sv
// Output-bus sequencer: one active transfer plus a one-entry pending request, issuing
// HEADER/STATUS/TAG/DATA word streams with back-to-back hand-over and early termination.
module encoder_seq_ctrl
    import encoder_seq_ctrl_pkg::*;
#(
    parameter int unsigned  BUS_SIZE  = 32,
    parameter int unsigned  BLCK_SIZE = 256,
    parameter int unsigned  TAG_SIZE  = 128,
    localparam int unsigned NW        = BLCK_SIZE / BUS_SIZE,
    localparam int unsigned NT        = TAG_SIZE / BUS_SIZE,
    localparam int unsigned CW        = cnt_width(NW)
) (
    input  logic          clk,
    input  logic          syn_rst,
    input  logic          req_valid,
    input  logic [1:0]    req_kind,
    input  logic [CW-1:0] req_nwm1,
    input  logic          req_last,
    output logic          req_ready,
    input  logic          unlock_dig_process,
    input  logic          ready_ext,
    input  logic          early_invalid,
    output logic          out_valid,
    output logic [1:0]    ctrl_mux_kind,
    output logic [CW-1:0] ctrl_mux_out,
    output logic          data_out_last,
    output logic          release_buffer,
    output logic          busy
);

    state_e        state_q, state_d;
    kind_e         act_kind_q, act_kind_d;
    logic [CW-1:0] act_max_q, act_max_d;
    logic          act_last_q, act_last_d;
    logic          pend_full_q, pend_full_d;
    kind_e         pend_kind_q, pend_kind_d;
    logic [CW-1:0] pend_max_q, pend_max_d;
    logic          pend_last_q, pend_last_d;
    logic          release_q, release_d;
    logic          busy_q;

    kind_e         req_kind_e;
    logic [CW-1:0] req_max;
    logic          req_fire;
    logic          word_accept;
    logic          word_final;
    logic          at_max;

    assign req_kind_e  = kind_e'(req_kind);
    assign req_ready   = ~syn_rst & ~pend_full_q & ~((req_kind_e == KindData) & ~unlock_dig_process);
    assign req_fire    = req_valid & req_ready;
    assign word_accept = out_valid & ready_ext;
    assign word_final  = word_accept & (at_max | early_invalid);

    // Requests carry their final word index so the counter compare is kind-agnostic.
    always_comb begin
        req_max = '0;
        case (req_kind_e)
            KindTag:  req_max = CW'(NT - 1);
            KindData: req_max = req_nwm1;
            default:  req_max = '0;
        endcase
    end

    encoder_seq_ctrl_word_cnt #(
        .CW(CW)
    ) u_word_cnt (
        .clk     (clk),
        .syn_rst (syn_rst),
        .clear   (word_final),
        .incr    (word_accept),
        .max_idx (act_max_q),
        .cnt     (ctrl_mux_out),
        .at_max  (at_max)
    );

    always_ff @(posedge clk) begin
        if (syn_rst) begin
            state_q     <= StIdle;
            act_kind_q  <= KindHeader;
            act_max_q   <= '0;
            act_last_q  <= 1'b0;
            pend_full_q <= 1'b0;
            pend_kind_q <= KindHeader;
            pend_max_q  <= '0;
            pend_last_q <= 1'b0;
            release_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            act_kind_q  <= act_kind_d;
            act_max_q   <= act_max_d;
            act_last_q  <= act_last_d;
            pend_full_q <= pend_full_d;
            pend_kind_q <= pend_kind_d;
            pend_max_q  <= pend_max_d;
            pend_last_q <= pend_last_d;
            release_q   <= release_d;
            busy_q      <= (state_d == StActive) | pend_full_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        act_kind_d  = act_kind_q;
        act_max_d   = act_max_q;
        act_last_d  = act_last_q;
        pend_full_d = pend_full_q;
        pend_kind_d = pend_kind_q;
        pend_max_d  = pend_max_q;
        pend_last_d = pend_last_q;
        release_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_fire) begin
                    state_d    = StActive;
                    act_kind_d = req_kind_e;
                    act_max_d  = req_max;
                    act_last_d = req_last;
                end
            end
            StActive: begin
                if (word_final) begin
                    release_d = (act_kind_q == KindData);
                    if (pend_full_q) begin
                        act_kind_d  = pend_kind_q;
                        act_max_d   = pend_max_q;
                        act_last_d  = pend_last_q;
                        pend_full_d = 1'b0;
                    end else if (req_fire) begin
                        act_kind_d = req_kind_e;
                        act_max_d  = req_max;
                        act_last_d = req_last;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (req_fire) begin
                    pend_full_d = 1'b1;
                    pend_kind_d = req_kind_e;
                    pend_max_d  = req_max;
                    pend_last_d = req_last;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        out_valid      = (state_q == StActive);
        ctrl_mux_kind  = act_kind_q;
        release_buffer = release_q;
        busy           = busy_q;
        data_out_last  = out_valid & act_last_q & (at_max | early_invalid);
    end

endmodule

// File: doc/encoder_seq_ctrl.md
ENCODER_SEQ_CTRL -- requirements
Module: encoder_seq_ctrl

Interface
REQ-001 Parameter BUS_SIZE, default 32, output bus word width in bits.
REQ-002 Parameter BLCK_SIZE, default 256, digested-block width in bits; NW = BLCK_SIZE/BUS_SIZE, CW = clog2(NW) (min 1).
REQ-003 Parameter TAG_SIZE, default 128, tag width in bits; NT = TAG_SIZE/BUS_SIZE, 1 <= NT <= NW.
REQ-004 Port clk, input, 1, single clock; all state updates on rising edge.
REQ-005 Port syn_rst, input, 1, reset, synchronous, active-high.
REQ-006 Port req_valid, input, 1, a transmit request is offered.
REQ-007 Port req_kind, input, 2, 0=HEADER, 1=STATUS, 2=TAG, 3=DATA.
REQ-008 Port req_nwm1, input, CW, DATA word count minus 1; ignored for other kinds.
REQ-009 Port req_last, input, 1, request closes the current instruction.
REQ-010 Port req_ready, output, 1, request accepted on edge where req_valid & req_ready.
REQ-011 Port unlock_dig_process, input, 1, DATA requests are acceptable only while high.
REQ-012 Port ready_ext, input, 1, downstream accepts the current word.
REQ-013 Port early_invalid, input, 1, terminate active transfer after the current accepted word.
REQ-014 Port out_valid, output, 1, a word is presented downstream.
REQ-015 Port ctrl_mux_kind, output, 2, kind of active transfer (datapath mux select).
REQ-016 Port ctrl_mux_out, output, CW, index of current word within the transfer.
REQ-017 Port data_out_last, output, 1, current word is the final word of an instruction.
REQ-018 Port release_buffer, output, 1, one-cycle pulse: DATA transfer completed, block buffer is free.
REQ-019 Port busy, output, 1, active transfer or pending request held.

Function
REQ-020 Word counts: HEADER/STATUS 1, TAG NT, DATA req_nwm1+1.
REQ-021 Word accepted = out_valid & ready_ext; ctrl_mux_out increments by 1 per accepted word, holds otherwise.
REQ-022 Final word = accepted word with ctrl_mux_out == count-1, or with early_invalid high.
REQ-023 Request accepted at edge k with no transfer active: out_valid high from cycle k+1, ctrl_mux_out = 0.
REQ-024 One-entry pending register: request accepted while a transfer is active is stored (kind, nwm1, last).
REQ-025 req_ready = ~syn_rst & ~pending_full & ~(req_kind==DATA & ~unlock_dig_process).
REQ-026 On the final-word edge, pending (if full) loads into active with no bubble; else a request accepted the same edge loads directly; else out_valid drops.
REQ-027 data_out_last = out_valid & active_last & (ctrl_mux_out == count-1 | early_invalid).
REQ-028 release_buffer pulses the cycle after the final word of a DATA transfer, including early_invalid termination.
REQ-029 early_invalid is ignored when no word is accepted that cycle.
REQ-030 Outputs out_valid, ctrl_mux_kind, ctrl_mux_out, release_buffer, busy driven from registers only; data_out_last and req_ready may be combinational.

Reset
REQ-031 syn_rst high: next edge clears active, pending, counter, kind, release_buffer; out_valid=0, ctrl_mux_out=0, ctrl_mux_kind=0, busy=0.
REQ-032 Reset mid-transfer drops the transfer and any pending request; no release_buffer pulse is generated.
REQ-033 No request is accepted in a cycle where syn_rst is high.

Structure
REQ-034 Kind codes, NW/NT/CW derivation and clog2 function reside in the shared encoder header.
REQ-035 State held in existing dff instances (ASYN=0); one sub-module enc_word_cnt (CW-bit counter, load/enable/terminal compare) is natural.

Verification
REQ-036 HEADER, ready_ext=1 -> out_valid one cycle, ctrl_mux_out=0, release_buffer never pulses.
REQ-037 DATA nwm1=7, last=1, ready_ext toggling 1,0 -> indices 0..7 each held until accepted, data_out_last only on index 7, release_buffer one pulse.
REQ-038 TAG (NT=4) then STATUS queued while active -> STATUS word immediately follows index 3, no idle cycle, req_ready low while pending full.
REQ-039 DATA nwm1=7, early_invalid with accepted index 2 -> out_valid low next cycle, release_buffer pulses, index 3 never shown.
REQ-040 DATA request with unlock_dig_process=0 -> req_ready=0; raise unlock -> accepted, 8 words follow.
REQ-041 syn_rst at index 4 of DATA with pending TAG -> all outputs 0 next cycle, no release_buffer, TAG never sent.
